alu_op_sequencer: RTL and testbench

- Issuing side of the 32-bit ALU interface: accepts one MIPS32 instruction word plus register operands over a valid/ready handshake.
- Decodes the instruction into the ALU's 4-bit ALUControl code and the A/B operands, drives them as registers, samples ALUResult/Zero, and returns a registered result over a second valid/ready handshake.
- Sits between the issue/register-read stage and the ALU in the multi-cycle datapath.

---
 rtl/alu_op_sequencer_if.sv | 35 +++
 rtl/alu_op_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Issue/result handshakes and ALU operand bus
// of the ALU op sequencer.
interface alu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_illegal;

  modport master (
    output in_valid, in_instr, in_rs, in_rt,
    output ALUResult, Zero, res_ready,
    input  in_ready, ALUControl, A, B,
    input  res_valid, res_data, res_zero,
    input  res_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs, in_rt,
    input  ALUResult, Zero, res_ready,
    output in_ready, ALUControl, A, B,
    output res_valid, res_data, res_zero,
    output res_illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one MIPS32 instruction to the ALU:
// decode, drive A/B/op, capture, respond.
module alu_op_sequencer #(
  parameter int SHAMT_W = 5
) (
  input logic Clk,
  input logic Reset,
  alu_op_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_NOR  = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SEXT = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MUL  = 4'b1001;
  localparam logic [3:0] C_SLL  = 4'b1010;
  localparam logic [3:0] C_CLZ  = 4'b1100;
  localparam logic [3:0] C_SRL  = 4'b1101;
  localparam logic [3:0] C_SLTU = 4'b1110;
  localparam logic [3:0] C_SRA  = 4'b1111;

  logic [1:0]  st;
  logic [31:0] instr_q, rs_q, rt_q;
  logic [3:0]  ctl_q;
  logic [31:0] a_q, b_q, data_q;
  logic        zero_q, ill_q;

  logic [5:0]  op, fn;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [31:0] sxi, zxi, rsa, rsr, sha, shr;
  logic [3:0]  d_ctl;
  logic [31:0] d_a, d_b;
  logic        d_ill;
  logic        unused_bits;

  assign op  = instr_q[31:26];
  assign fn  = instr_q[5:0];
  assign sh  = instr_q[10:6];
  assign imm = instr_q[15:0];
  assign sxi = {{16{imm[15]}}, imm};
  assign zxi = {16'b0, imm};
  assign sha = {27'b0, sh};
  assign shr = {26'b0, instr_q[21], sh};
  assign rsa = {{(32-SHAMT_W){1'b0}},
                rs_q[SHAMT_W-1:0]};
  assign rsr = {{(31-SHAMT_W){1'b0}},
                instr_q[6], rs_q[SHAMT_W-1:0]};
  assign unused_bits = ^{instr_q[25:22],
                         instr_q[20:16]};

  // Map the latched instruction to op code and operands
  always_comb begin
    d_ctl = C_AND;
    d_a   = '0;
    d_b   = '0;
    d_ill = 1'b0;
    unique case (1'b1)
      op == 6'h00: begin
        d_a = rs_q;
        d_b = rt_q;
        case (fn)
          6'h20, 6'h21: d_ctl = C_ADD;
          6'h22, 6'h23: d_ctl = C_SUB;
          6'h24: d_ctl = C_AND;
          6'h25: d_ctl = C_OR;
          6'h26: d_ctl = C_XOR;
          6'h27: d_ctl = C_NOR;
          6'h2A: d_ctl = C_SLT;
          6'h2B: d_ctl = C_SLTU;
          6'h00: begin
            d_ctl = C_SLL; d_a = rt_q; d_b = sha;
          end
          6'h02: begin
            d_ctl = C_SRL; d_a = rt_q; d_b = shr;
          end
          6'h03: begin
            d_ctl = C_SRA; d_a = rt_q; d_b = sha;
          end
          6'h04: begin
            d_ctl = C_SLL; d_a = rt_q; d_b = rsa;
          end
          6'h06: begin
            d_ctl = C_SRL; d_a = rt_q; d_b = rsr;
          end
          6'h07: begin
            d_ctl = C_SRA; d_a = rt_q; d_b = rsa;
          end
          default: d_ill = 1'b1;
        endcase
      end
      op == 6'h1C: begin
        d_a = rs_q;
        case (fn)
          6'h02: begin d_ctl = C_MUL; d_b = rt_q; end
          6'h20: d_ctl = C_CLZ;
          default: d_ill = 1'b1;
        endcase
      end
      op == 6'h1F: begin
        d_ctl = C_SEXT;
        d_a   = rt_q;
        if (fn == 6'h20 && sh == 5'h10)
          d_b = 32'd0;
        else if (fn == 6'h20 && sh == 5'h18)
          d_b = 32'd1;
        else
          d_ill = 1'b1;
      end
      op == 6'h08 || op == 6'h09: begin
        d_ctl = C_ADD; d_a = rs_q; d_b = sxi;
      end
      op == 6'h0A: begin
        d_ctl = C_SLT; d_a = rs_q; d_b = sxi;
      end
      op == 6'h0B: begin
        d_ctl = C_SLTU; d_a = rs_q; d_b = sxi;
      end
      op == 6'h0C: begin
        d_ctl = C_AND; d_a = rs_q; d_b = zxi;
      end
      op == 6'h0D: begin
        d_ctl = C_OR; d_a = rs_q; d_b = zxi;
      end
      op == 6'h0E: begin
        d_ctl = C_XOR; d_a = rs_q; d_b = zxi;
      end
      op == 6'h0F: begin
        d_ctl = C_OR; d_a = {imm, 16'b0};
      end
      op == 6'h04 || op == 6'h05: begin
        d_ctl = C_SUB; d_a = rs_q; d_b = rt_q;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_ctl = C_AND;
      d_a   = '0;
      d_b   = '0;
    end
  end

  // Sequencer FSM with operand and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st      <= IDLE;
      instr_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          instr_q <= bus.in_instr;
          rs_q    <= bus.in_rs;
          rt_q    <= bus.in_rt;
          ill_q   <= 1'b0;
          st      <= DECODE;
        end
        DECODE: begin
          ctl_q <= d_ctl;
          a_q   <= d_a;
          b_q   <= d_b;
          if (d_ill) begin
            ill_q  <= 1'b1;
            data_q <= '0;
            zero_q <= 1'b0;
            st     <= RESP;
          end else begin
            st <= EXEC;
          end
        end
        EXEC: begin
          data_q <= bus.ALUResult;
          zero_q <= bus.Zero;
          st     <= RESP;
        end
        default: if (bus.res_ready) st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (st == IDLE);
  assign bus.res_valid   = (st == RESP);
  assign bus.ALUControl  = ctl_q;
  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.res_data    = data_q;
  assign bus.res_zero    = zero_q;
  assign bus.res_illegal = ill_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a
// behavioural ALU on the operand bus.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.SHAMT_W(5)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] clz32(
    input logic [31:0] v
  );
    int c;
    c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) break;
      c++;
    end
    return 32'(c);
  endfunction

  // Behavioural ALU driven by the sequencer
  always_comb begin
    logic [31:0] r;
    logic [63:0] rr;
    logic [31:0] a;
    logic [31:0] b;
    a  = bus.A;
    b  = bus.B;
    rr = {a, a} >> b[4:0];
    case (bus.ALUControl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0011: r = ~(a | b);
      4'b0100: r = a ^ b;
      4'b0101: r = b[0] ? {{16{a[15]}}, a[15:0]}
                        : {{24{a[7]}}, a[7:0]};
      4'b0110: r = a - b;
      4'b0111: r = {31'b0, $signed(a) < $signed(b)};
      4'b1001: r = a * b;
      4'b1010: r = a << b[4:0];
      4'b1011: r = {31'b0, $signed(a) > $signed(b)};
      4'b1100: r = clz32(a);
      4'b1101: r = b[5] ? rr[31:0] : (a >> b[4:0]);
      4'b1110: r = {31'b0, a < b};
      4'b1111: r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    bus.ALUResult = r;
    bus.Zero      = (r == 32'd0);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        ill;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        zero;
  } vec_t;

  vec_t vt[17];

  task automatic accept(input logic [31:0] ins,
                        input logic [31:0] rs,
                        input logic [31:0] rt);
    int k;
    k = 0;
    while (!bus.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("acc_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 1;
    while (!bus.res_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_res;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t x);
    int n;
    accept(x.instr, x.rs, x.rt);
    wait_res(n);
    chk({x.nm, "_lat"}, 32'(n), x.ill ? 32'd2 : 32'd3);
    if (!x.ill) begin
      chk({x.nm, "_ctl"}, 32'(bus.ALUControl),
          32'(x.ctl));
      chk({x.nm, "_a"}, bus.A, x.a);
      chk({x.nm, "_b"}, bus.B, x.b);
    end
    chk({x.nm, "_data"}, bus.res_data, x.data);
    chk({x.nm, "_zero"}, 32'(bus.res_zero),
        32'(x.zero));
    chk({x.nm, "_ill"}, 32'(bus.res_illegal),
        32'(x.ill));
    release_res();
    chk({x.nm, "_idle"}, 32'(bus.in_ready), 32'd1);
    chk({x.nm, "_rvlo"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    int n;
    bit seen;
    vt[0]  = '{"addi", 32'h2022FFFF, 32'h5, 32'h0,
               1'b0, 4'b0010, 32'h5, 32'hFFFFFFFF,
               32'h4, 1'b0};
    vt[1]  = '{"beq", 32'h10220010, 32'h1234ABCD,
               32'h1234ABCD, 1'b0, 4'b0110,
               32'h1234ABCD, 32'h1234ABCD,
               32'h0, 1'b1};
    vt[2]  = '{"bne", 32'h14220010, 32'h1, 32'h2,
               1'b0, 4'b0110, 32'h1, 32'h2,
               32'hFFFFFFFF, 1'b0};
    vt[3]  = '{"rotr", 32'h00221902, 32'h0, 32'hF,
               1'b0, 4'b1101, 32'hF, 32'h24,
               32'hF0000000, 1'b0};
    vt[4]  = '{"srl", 32'h00021902, 32'h0, 32'hF,
               1'b0, 4'b1101, 32'hF, 32'h04,
               32'h0, 1'b1};
    vt[5]  = '{"seh", 32'h7C021E20, 32'h0,
               32'h00008001, 1'b0, 4'b0101,
               32'h00008001, 32'h1,
               32'hFFFF8001, 1'b0};
    vt[6]  = '{"ori", 32'h34028001, 32'h0, 32'h0,
               1'b0, 4'b0001, 32'h0, 32'h8001,
               32'h00008001, 1'b0};
    vt[7]  = '{"sub", 32'h00221822, 32'd10, 32'd3,
               1'b0, 4'b0110, 32'd10, 32'd3,
               32'd7, 1'b0};
    vt[8]  = '{"sllv", 32'h00221804, 32'h24, 32'h1,
               1'b0, 4'b1010, 32'h1, 32'h4,
               32'h10, 1'b0};
    vt[9]  = '{"lui", 32'h3C021234, 32'hDEAD,
               32'h0, 1'b0, 4'b0001, 32'h12340000,
               32'h0, 32'h12340000, 1'b0};
    vt[10] = '{"mul", 32'h70221802, 32'd6, 32'd7,
               1'b0, 4'b1001, 32'd6, 32'd7,
               32'd42, 1'b0};
    vt[11] = '{"srav", 32'h00221807, 32'h3,
               32'h80000000, 1'b0, 4'b1111,
               32'h80000000, 32'h3,
               32'hF0000000, 1'b0};
    vt[12] = '{"slti", 32'h2822FFFF, 32'hFFFFFFFE,
               32'h0, 1'b0, 4'b0111, 32'hFFFFFFFE,
               32'hFFFFFFFF, 32'h1, 1'b0};
    vt[13] = '{"seb", 32'h7C021C20, 32'h0, 32'h80,
               1'b0, 4'b0101, 32'h80, 32'h0,
               32'hFFFFFF80, 1'b0};
    vt[14] = '{"ill_op", 32'hFC000000, 32'h1,
               32'h2, 1'b1, 4'b0000, 32'h0, 32'h0,
               32'h0, 1'b0};
    vt[15] = '{"ill_fn", 32'h00221801, 32'h1,
               32'h2, 1'b1, 4'b0000, 32'h0, 32'h0,
               32'h0, 1'b0};
    vt[16] = '{"ill_sh", 32'h7C021C60, 32'h1,
               32'h2, 1'b1, 4'b0000, 32'h0, 32'h0,
               32'h0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_zero", 32'(bus.res_zero), 32'd0);
    chk("rst_res_ill", 32'(bus.res_illegal), 32'd0);
    chk("rst_ctl", 32'(bus.ALUControl), 32'd0);
    chk("rst_a", bus.A, 32'd0);
    chk("rst_b", bus.B, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) run_vec(vt[i]);

    accept(32'hFC000000, 32'h0, 32'h0);
    wait_res(n);
    chk("hold_lat", 32'(n), 32'd2);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h2022FFFF;
    bus.in_rs    = 32'h5;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_ill", 32'(bus.res_illegal), 32'd1);
      chk("hold_data", bus.res_data, 32'd0);
    end
    bus.in_valid = 1'b0;
    release_res();
    chk("hold_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk("hold_noacc", 32'(bus.in_ready), 32'd1);
    run_vec(vt[0]);

    accept(32'h0022182A, 32'h1, 32'h2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mrst_res_valid", 32'(bus.res_valid),
        32'd0);
    chk("mrst_ctl", 32'(bus.ALUControl), 32'd0);
    chk("mrst_a", bus.A, 32'd0);
    chk("mrst_b", bus.B, 32'd0);
    chk("mrst_data", bus.res_data, 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.res_valid) seen = 1'b1;
    end
    chk("mrst_noresp", 32'(seen), 32'd0);
    run_vec('{"clz", 32'h70200020, 32'h00010000,
              32'h0, 1'b0, 4'b1100, 32'h00010000,
              32'h0, 32'd15, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
